// File: rtl/sram_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed 1w1r FIFO controller and its output buffer.
package sram_fifo_pkg;

   localparam int OBUF_DEPTH = 3;
   localparam int OBUF_CNT_W = 2;

   // Width that holds every occupancy from 0 to depth + OBUF_DEPTH.
   function automatic int level_width(input int depth);
      return $clog2(depth + OBUF_DEPTH + 1);
   endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Three-entry register FIFO that absorbs the macro's read latency; entry 0 is always the head.
module sram_fifo_obuf
   import sram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 120
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [OBUF_CNT_W-1:0] count
);

   logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [OBUF_DEPTH];
   logic [OBUF_CNT_W-1:0] cnt_q;
   logic [OBUF_CNT_W-1:0] cnt_d;
   logic [OBUF_CNT_W-1:0] wr_idx;

   // Pop shifts toward the head, so a simultaneous push lands one slot lower.
   always_comb begin
      mem_d  = mem_q;
      wr_idx = cnt_q;
      if (pop) begin
         for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         wr_idx = cnt_q - OBUF_CNT_W'(1);
      end
      if (push) begin
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            if (wr_idx == OBUF_CNT_W'(i)) begin
               mem_d[i] = push_data;
            end
         end
      end
      cnt_d = cnt_q + OBUF_CNT_W'(push) - OBUF_CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // NOTE: the data slots carry no reset; the count gates them, so their power-up contents are never observed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_data = mem_q[0];
   assign count     = cnt_q;

endmodule

// File: rtl/sram_1w1r_fifo_ctrl.sv
// Valid/ready FIFO controller around a 1w1r SRAM macro: pointers, occupancy, read issue and macro port drive.
module sram_1w1r_fifo_ctrl
   import sram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 120,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH+1:0] level,
   output logic                  sram_csb0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   localparam int DEPTH       = 1 << ADDR_WIDTH;
   localparam int CNT_W       = ADDR_WIDTH + 1;
   localparam int LVL_W       = level_width(DEPTH);
   localparam int LEVEL_OUT_W = ADDR_WIDTH + 2;

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]      sram_cnt_q, sram_cnt_d;
   logic                  inflight_q, inflight_d;
   logic                  run_q, run_d;
   logic [LVL_W-1:0]      level_q, level_d;

   logic                  wr;
   logic                  rd;
   logic                  pop;
   logic [OBUF_CNT_W-1:0] obuf_cnt;

   // run_q holds in_ready low until the first edge after reset releases.
   assign in_ready  = run_q & (sram_cnt_q < CNT_W'(DEPTH));
   assign wr        = in_valid & in_ready;
   assign rd        = (sram_cnt_q != '0) &
                      (({1'b0, obuf_cnt} + {2'b00, inflight_q}) < 3'(OBUF_DEPTH));
   assign out_valid = (obuf_cnt != '0);
   assign pop       = out_valid & out_ready;

   assign sram_csb0  = ~wr;
   assign sram_addr0 = wptr_q;
   assign sram_din0  = in_data;
   assign sram_csb1  = ~rd;
   assign sram_addr1 = rptr_q;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      run_d      = 1'b1;
      inflight_d = rd;
      if (wr) begin
         wptr_d = wptr_q + ADDR_WIDTH'(1);
      end
      if (rd) begin
         rptr_d = rptr_q + ADDR_WIDTH'(1);
      end
      sram_cnt_d = sram_cnt_q + CNT_W'(wr) - CNT_W'(rd);
      // Issue and capture only move words between stages; occupancy changes on accept and pop alone.
      level_d    = level_q + LVL_W'(wr) - LVL_W'(pop);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         sram_cnt_q <= '0;
         inflight_q <= 1'b0;
         run_q      <= 1'b0;
         level_q    <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         sram_cnt_q <= sram_cnt_d;
         inflight_q <= inflight_d;
         run_q      <= run_d;
         level_q    <= level_d;
      end
   end

   // Read data is valid only at the edge right after issue, which is exactly when inflight_q is set.
   sram_fifo_obuf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_obuf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (sram_dout1),
      .pop       (pop),
      .head_data (out_data),
      .count     (obuf_cnt)
   );

   assign level = LEVEL_OUT_W'(level_q);

endmodule
